// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: default width and FSM encoding.
package serial_arith_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub16_if.sv
// Operand/result bundle between the negator-side requester and the serial subtractor.
interface serial_sub16_if #(parameter int WIDTH = serial_arith_pkg::DEF_WIDTH);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b_bar;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b_bar,
    input  diff, borrow, overflow, busy, done
  );

  modport slave (
    input  start, a, b_bar,
    output diff, borrow, overflow, busy, done
  );

endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder from two-input NANDs, matching the gate-level style of the negator.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic n1, n2, n3, h, n5, n6, n7;

  // Classic nine-NAND adder: first half-adder on x/y, second on h/cin.
  assign n1   = ~(x & y);
  assign n2   = ~(x & n1);
  assign n3   = ~(y & n1);
  assign h    = ~(n2 & n3);
  assign n5   = ~(h & cin);
  assign n6   = ~(h & n5);
  assign n7   = ~(cin & n5);
  assign s    = ~(n6 & n7);
  assign cout = ~(n1 & n5);

endmodule

// File: rtl/serial_sub16.sv
// Bit-serial subtractor: a + b_bar + 1, LSB first, one full adder and a registered carry.
module serial_sub16
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_sub16_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, ovf_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_cout;
  logic             last_bit;

  full_adder_bit u_fa (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CW'(WIDTH-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start) begin
          a_sr  <= bus.a;
          b_sr  <= bus.b_bar;
          carry <= 1'b1;  // the +1 of two's-complement negation
          cnt   <= '0;
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {fa_s, res_sr[WIDTH-1:1]};
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          // On the MSB bit, 'carry' is still the carry into the MSB.
          if (last_bit) begin
            diff_q   <= {fa_s, res_sr[WIDTH-1:1]};
            borrow_q <= ~fa_cout;
            ovf_q    <= carry ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_serial_sub16.sv
// Randomized and directed checks of serial_sub16 against an arithmetic reference model.
module tb_serial_sub16;
  import serial_arith_pkg::*;

  localparam int W = DEF_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [W-1:0] last_diff;

  serial_sub16_if #(.WIDTH(W)) bus ();

  serial_sub16 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned/signed arithmetic on the recovered subtrahend.
  function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] bb,
                                  output logic [W-1:0] d, output logic br, output logic ov);
    logic [W-1:0] b;
    b  = ~bb;
    d  = a - b;
    br = (a < b);
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  // Issues one operation from an idle DUT and waits (bounded) for done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] bb,
                       output logic [W-1:0] d, output logic br, output logic ov,
                       output int lat, output int busyc, output logic [W-1:0] d_mid);
    @(negedge clk);
    bus.a = a; bus.b_bar = bb; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b_bar = W'($urandom);
    d_mid = bus.diff;
    lat = 0; busyc = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busyc++;
      @(negedge clk);
      lat++;
    end
    d = bus.diff; br = bus.borrow; ov = bus.overflow;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a = '0; bus.b_bar = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.diff, bus.borrow, bus.overflow, bus.busy, bus.done} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got diff=%h br=%b ov=%b busy=%b done=%b, need all 0",
               bus.diff, bus.borrow, bus.overflow, bus.busy, bus.done);
    end
    rst = 1'b0;
    last_diff = '0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{16'h0005, 16'h0003, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'd100};
    logic [W-1:0] tb [7] = '{16'hFFFE, 16'hFFFA, 16'hFFFE, 16'h0000, 16'hFFFF, 16'hFFFE, ~16'd58};
    logic [W-1:0] td [7] = '{16'h0004, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h002A};
    logic         tr [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         tv [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] d, dm;
    logic br, ov;
    int lat, bc;
    for (int i = 0; i < 7; i++) begin
      do_op(ta[i], tb[i], d, br, ov, lat, bc, dm);
      n_cmp++;
      if (lat !== 16 || bc !== 16) begin
        n_bad++;
        $display("FAIL dir_timing[%0d]: latency=%0d busy_cycles=%0d, need 16/16", i, lat, bc);
      end
      n_cmp++;
      if (d !== td[i] || br !== tr[i] || ov !== tv[i]) begin
        n_bad++;
        $display("FAIL dir_result[%0d]: got %h/%b/%b, need %h/%b/%b", i, d, br, ov, td[i], tr[i], tv[i]);
      end
      n_cmp++;
      if (dm !== last_diff) begin
        n_bad++;
        $display("FAIL dir_hold[%0d]: diff during run %h, need %h", i, dm, last_diff);
      end
      last_diff = td[i];
      @(negedge clk);
      n_cmp++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.diff !== td[i]) begin
        n_bad++;
        $display("FAIL dir_after[%0d]: done=%b busy=%b diff=%h, need 0/0/%h", i, bus.done, bus.busy, bus.diff, td[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, bb, d, dm, ed;
    logic br, ov, ebr, eov;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       a = W'($urandom_range(0, 3)) ^ {W{$urandom_range(0, 1) == 1}};
        1:       a = {1'b1, W'($urandom) >> 1};
        default: a = W'($urandom);
      endcase
      bb = W'($urandom);
      ref_sub(a, bb, ed, ebr, eov);
      do_op(a, bb, d, br, ov, lat, bc, dm);
      n_cmp++;
      if (d !== ed || br !== ebr || ov !== eov || lat !== 16) begin
        n_bad++;
        $display("FAIL rand[%0d] a=%h bb=%h: got %h/%b/%b lat=%0d, need %h/%b/%b lat=16",
                 i, a, bb, d, br, ov, lat, ed, ebr, eov);
      end
      n_cmp++;
      if (dm !== last_diff) begin
        n_bad++;
        $display("FAIL rand_hold[%0d]: diff during run %h, need %h", i, dm, last_diff);
      end
      last_diff = ed;
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] a, bb, ed, d;
    logic ebr, eov, br, ov;
    int dones, lat;
    a = W'($urandom); bb = W'($urandom);
    ref_sub(a, bb, ed, ebr, eov);
    dones = 0; lat = -1; d = '0; br = 1'b0; ov = 1'b0;
    @(negedge clk);
    bus.a = a; bus.b_bar = bb; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (dones == 1) begin lat = k; d = bus.diff; br = bus.borrow; ov = bus.overflow; end
      end
      // Pokes start mid-RUN and again while in DONE; both must be dropped.
      bus.start = (k == 5) || bus.done;
      bus.a = ~a; bus.b_bar = ~bb;
    end
    n_cmp++;
    if (dones !== 1 || lat !== 16) begin
      n_bad++;
      $display("FAIL ignore_start_pulses: done pulses=%0d at %0d, need 1 at 16", dones, lat);
    end
    n_cmp++;
    if (d !== ed || br !== ebr || ov !== eov || bus.diff !== ed || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_start_result: got %h/%b/%b held=%h busy=%b, need %h/%b/%b busy=0",
               d, br, ov, bus.diff, bus.busy, ed, ebr, eov);
    end
    last_diff = ed;
  endtask

  task automatic test_start_held();
    logic [W-1:0] a, bb, ed;
    logic ebr, eov;
    int t, nd;
    int tdone [3];
    logic [W-1:0] dv [3];
    a = W'($urandom); bb = W'($urandom);
    ref_sub(a, bb, ed, ebr, eov);
    t = 0; nd = 0;
    @(negedge clk);
    bus.a = a; bus.b_bar = bb; bus.start = 1'b1;
    while (nd < 3 && t < 80) begin
      @(negedge clk);
      t++;
      if (bus.done) begin tdone[nd] = t; dv[nd] = bus.diff; nd++; end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (nd !== 3) begin
      n_bad++;
      $display("FAIL held_count: %0d done pulses in %0d cycles, need 3", nd, t);
    end else begin
      n_cmp++;
      if (tdone[1] - tdone[0] !== 18 || tdone[2] - tdone[1] !== 18) begin
        n_bad++;
        $display("FAIL held_spacing: gaps %0d,%0d, need 18,18", tdone[1] - tdone[0], tdone[2] - tdone[1]);
      end
      n_cmp++;
      if (dv[0] !== ed || dv[1] !== ed || dv[2] !== ed) begin
        n_bad++;
        $display("FAIL held_result: got %h,%h,%h, need %h", dv[0], dv[1], dv[2], ed);
      end
    end
    last_diff = ed;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] d, dm;
    logic br, ov;
    int dones, lat, bc;
    @(negedge clk);
    bus.a = 16'hFFFF; bus.b_bar = 16'h0000; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.diff, bus.borrow, bus.overflow, bus.busy, bus.done} !== '0) begin
      n_bad++;
      $display("FAIL midrun_reset: got diff=%h br=%b ov=%b busy=%b done=%b, need all 0",
               bus.diff, bus.borrow, bus.overflow, bus.busy, bus.done);
    end
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL midrun_abandon: %0d cycles of done/busy after reset, need 0", dones);
    end
    do_op(16'd100, ~16'd58, d, br, ov, lat, bc, dm);
    n_cmp++;
    if (d !== 16'h002A || br !== 1'b0 || ov !== 1'b0 || lat !== 16 || dm !== '0) begin
      n_bad++;
      $display("FAIL midrun_fresh: got %h/%b/%b lat=%0d mid=%h, need 002a/0/0 lat=16 mid=0000",
               d, br, ov, lat, dm);
    end
    last_diff = 16'h002A;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_start_held();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
